regfile_mp: RTL



---
 rtl/regfile_pkg.sv | 43 ++++
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 94 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   localparam int unsigned DEF_XLEN  = 32;
   localparam int unsigned DEF_DEPTH = 32;

   // Upper bounds for the padded write-port buses the helpers operate on.
   localparam int unsigned MAX_WR = 8;
   localparam int unsigned MAX_AW = 16;
   localparam int unsigned WIDX_W = $clog2(MAX_WR);

   typedef logic [DEF_XLEN-1:0] word_t;

   typedef struct packed {
      logic              hit;
      logic [WIDX_W-1:0] idx;
   } wr_hit_t;

   // True when the address names a writable, readable architectural register.
   function automatic logic addr_legal(input logic [MAX_AW-1:0] addr,
                                       input int unsigned      depth,
                                       input bit               zero_reg);
      return (32'(addr) < depth) && !(zero_reg && (addr == '0));
   endfunction

   // Finds the highest-index enabled write port targeting addr. The enables
   // must already be masked with address legality.
   function automatic wr_hit_t highest_wr_hit(input logic [MAX_AW-1:0]             addr,
                                              input logic [MAX_WR-1:0]             en,
                                              input logic [MAX_WR-1:0][MAX_AW-1:0] waddr);
      wr_hit_t r;
      r.hit = 1'b0;
      r.idx = '0;
      for (int unsigned p = 0; p < MAX_WR; p++) begin
         if (en[p] && (waddr[p] == addr)) begin
            r.hit = 1'b1;
            r.idx = WIDX_W'(p);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/busy-set bus of the multi-port register file.
interface regfile_mp_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [NUM_WR-1:0]           wr_en;
   logic [NUM_WR-1:0][AW-1:0]   wr_addr;
   logic [NUM_WR-1:0][XLEN-1:0] wr_data;
   logic [NUM_RD-1:0][AW-1:0]   rd_addr;
   logic [NUM_RD-1:0][XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]           rd_busy;
   logic                        busy_set_en;
   logic [AW-1:0]               busy_set_addr;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, busy_set_en, busy_set_addr,
      input  rd_data, rd_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, busy_set_en, busy_set_addr,
      output rd_data, rd_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback, set wins.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned  DEPTH    = 32,
   parameter int unsigned  NUM_RD   = 2,
   parameter bit           ZERO_REG = 1'b1,
   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [MAX_WR-1:0]             i_clr_en,
   input  logic [MAX_WR-1:0][MAX_AW-1:0] i_clr_addr,
   input  logic                          i_set_en,
   input  logic [AW-1:0]                 i_set_addr,
   input  logic [NUM_RD-1:0][AW-1:0]     i_rd_addr,
   input  logic [NUM_RD-1:0]             i_rd_byp,
   output logic [NUM_RD-1:0]             o_rd_busy
);

   logic r_busy [DEPTH];
   logic w_set_legal;

   // Qualify the issue-stage set request with address legality.
   always_comb begin
      w_set_legal = i_set_en && addr_legal(MAX_AW'(i_set_addr), DEPTH, ZERO_REG);
   end

   // Busy update; a same-cycle set overrides the clear since the new producer is already issued.
   always_ff @(posedge clock) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
         if (reset) begin
            r_busy[r] <= 1'b0;
         end else if (w_set_legal && (i_set_addr == AW'(r))) begin
            r_busy[r] <= 1'b1;
         end else if (highest_wr_hit(MAX_AW'(r), i_clr_en, i_clr_addr).hit) begin
            r_busy[r] <= 1'b0;
         end
      end
   end

   // Busy lookup per read port; a bypassed write makes the value available now.
   always_comb begin
      o_rd_busy = '0;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
         if (!reset && addr_legal(MAX_AW'(i_rd_addr[j]), DEPTH, ZERO_REG)) begin
            o_rd_busy[j] = r_busy[i_rd_addr[j]] && !i_rd_byp[j];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass and busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned  XLEN     = DEF_XLEN,
   parameter int unsigned  DEPTH    = DEF_DEPTH,
   parameter int unsigned  NUM_RD   = 2,
   parameter int unsigned  NUM_WR   = 1,
   parameter bit           BYPASS   = 1'b1,
   parameter bit           ZERO_REG = 1'b1,
   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input logic         clock,
   input logic         reset,
   regfile_mp_if.slave bus
);

   logic [XLEN-1:0]               r_mem [DEPTH];
   logic [MAX_WR-1:0]             w_wen_legal;
   logic [MAX_WR-1:0][MAX_AW-1:0] w_waddr_pad;
   logic [MAX_WR-1:0][XLEN-1:0]   w_wdata_pad;
   wr_hit_t                       w_reg_hit [DEPTH];
   wr_hit_t                       w_rd_hit  [NUM_RD];
   logic [NUM_RD-1:0]             w_rd_byp;
   logic [NUM_RD-1:0][XLEN-1:0]   w_rd_data;
   logic [NUM_RD-1:0]             w_rd_busy;

   // Pad write ports to the helper width and drop illegal-address writes.
   always_comb begin
      w_wen_legal = '0;
      w_waddr_pad = '0;
      w_wdata_pad = '0;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         w_waddr_pad[p] = MAX_AW'(bus.wr_addr[p]);
         w_wdata_pad[p] = bus.wr_data[p];
         w_wen_legal[p] = bus.wr_en[p] && addr_legal(MAX_AW'(bus.wr_addr[p]), DEPTH, ZERO_REG);
      end
   end

   // Per-register write resolution; highest port index wins on conflicts.
   always_comb begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
         w_reg_hit[r] = highest_wr_hit(MAX_AW'(r), w_wen_legal, w_waddr_pad);
      end
   end

   // Data array update; reset clears everything and discards this cycle's writes.
   always_ff @(posedge clock) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
         if (reset) begin
            r_mem[r] <= '0;
         end else if (w_reg_hit[r].hit) begin
            r_mem[r] <= w_wdata_pad[w_reg_hit[r].idx];
         end
      end
   end

   // Zero-latency reads with optional same-cycle forwarding from the write ports.
   always_comb begin
      w_rd_data = '0;
      w_rd_byp  = '0;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
         w_rd_hit[j] = highest_wr_hit(MAX_AW'(bus.rd_addr[j]), w_wen_legal, w_waddr_pad);
         w_rd_byp[j] = BYPASS && w_rd_hit[j].hit;
         if (!reset && addr_legal(MAX_AW'(bus.rd_addr[j]), DEPTH, ZERO_REG)) begin
            if (w_rd_byp[j]) begin
               w_rd_data[j] = w_wdata_pad[w_rd_hit[j].idx];
            end else begin
               w_rd_data[j] = r_mem[bus.rd_addr[j]];
            end
         end
      end
   end

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .i_clr_en   (w_wen_legal),
      .i_clr_addr (w_waddr_pad),
      .i_set_en   (bus.busy_set_en),
      .i_set_addr (bus.busy_set_addr),
      .i_rd_addr  (bus.rd_addr),
      .i_rd_byp   (w_rd_byp),
      .o_rd_busy  (w_rd_busy)
   );

   assign bus.rd_data = w_rd_data;
   assign bus.rd_busy = w_rd_busy;

endmodule
